// File: rtl/card_pkg.sv
// Shared flip-state encoding, default grid geometry and colours for the card renderer.
package card_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHRINK = 2'd1;
    localparam logic [1:0] ST_GROW   = 2'd2;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 4;
    localparam int DEF_CARD_W   = 90;
    localparam int DEF_CARD_H   = 90;
    localparam int DEF_PITCH_X  = 100;
    localparam int DEF_PITCH_Y  = 100;
    localparam int DEF_ORIGIN_X = 130;
    localparam int DEF_ORIGIN_Y = 70;
    localparam int DEF_STEP     = 10;

    localparam logic [2:0] DEF_BACK_RGB = 3'b100;
    localparam logic [2:0] BG_RGB       = 3'b000;

    // A card of visible width w is centred in its box; the band is [(cw-w)/2, (cw+w)/2).
    function automatic logic in_band(input int lx, input int w, input int card_w);
        return (lx >= ((card_w - w) >>> 1)) && (lx < ((card_w + w) >>> 1));
    endfunction

endpackage

// File: rtl/card_flip_ctrl.sv
// Flip animation FSM: owns the face-up state of every card and the width of the card being flipped.
module card_flip_ctrl
    import card_pkg::*;
#(
    parameter int N      = 16,
    parameter int IW     = 4,
    parameter int CARD_W = 90,
    parameter int STEP   = 10,
    parameter int WW     = $clog2(CARD_W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          flip_req,
    input  logic [IW-1:0] flip_pos,
    input  logic          flip_face,
    input  logic          reset_board,
    output logic          flip_busy,
    output logic [N-1:0]  face_up,
    output logic [WW-1:0] w,
    output logic [IW-1:0] fpos
);

    logic [1:0] state;
    logic       ftgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            w         <= WW'(CARD_W);
            fpos      <= '0;
            ftgt      <= 1'b0;
            face_up   <= '0;
            flip_busy <= 1'b0;
        end else if (reset_board) begin
            state     <= ST_IDLE;
            w         <= WW'(CARD_W);
            face_up   <= '0;
            flip_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flip_req && (int'(flip_pos) < N)) begin
                        fpos      <= flip_pos;
                        ftgt      <= flip_face;
                        state     <= ST_SHRINK;
                        flip_busy <= 1'b1;
                    end
                end
                ST_SHRINK: begin
                    // The face swaps on the frame where the card is edge-on.
                    if (frame_start) begin
                        if (int'(w) > STEP) begin
                            w <= w - WW'(STEP);
                        end else begin
                            w             <= '0;
                            face_up[fpos] <= ftgt;
                            state         <= ST_GROW;
                        end
                    end
                end
                ST_GROW: begin
                    if (frame_start) begin
                        if (int'(w) + STEP < CARD_W) begin
                            w <= w + WW'(STEP);
                        end else begin
                            w         <= WW'(CARD_W);
                            state     <= ST_IDLE;
                            flip_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    w         <= WW'(CARD_W);
                    flip_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/card_grid_flip_renderer.sv
// ROWS x COLS memory-game card grid on the VGA raster: grid hit-test, flip band and 2-stage pixel pipeline.
module card_grid_flip_renderer
    import card_pkg::*;
#(
    parameter int          ROWS     = DEF_ROWS,
    parameter int          COLS     = DEF_COLS,
    parameter int          CARD_W   = DEF_CARD_W,
    parameter int          CARD_H   = DEF_CARD_H,
    parameter int          PITCH_X  = DEF_PITCH_X,
    parameter int          PITCH_Y  = DEF_PITCH_Y,
    parameter int          ORIGIN_X = DEF_ORIGIN_X,
    parameter int          ORIGIN_Y = DEF_ORIGIN_Y,
    parameter int          STEP     = DEF_STEP,
    parameter logic [2:0]  BACK_RGB = DEF_BACK_RGB,
    localparam int         N        = ROWS * COLS,
    localparam int         IW       = $clog2(N),
    localparam int         AW       = $clog2(CARD_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          hcount,
    input  logic [9:0]          vcount,
    input  logic                frame_start,
    input  logic                flip_req,
    input  logic [IW-1:0]       flip_pos,
    input  logic                flip_face,
    input  logic                reset_board,
    output logic                flip_busy,
    output logic [N-1:0]        face_up,
    output logic [AW-1:0]       rom_addr,
    input  logic [3*CARD_W-1:0] rom_data,
    output logic                cardon,
    output logic [2:0]          rgb
);

    localparam int LXW = $clog2(CARD_W);
    localparam int WW  = $clog2(CARD_W + 1);

    logic [WW-1:0] w;
    logic [IW-1:0] fpos;

    card_flip_ctrl #(
        .N      (N),
        .IW     (IW),
        .CARD_W (CARD_W),
        .STEP   (STEP),
        .WW     (WW)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .flip_req    (flip_req),
        .flip_pos    (flip_pos),
        .flip_face   (flip_face),
        .reset_board (reset_board),
        .flip_busy   (flip_busy),
        .face_up     (face_up),
        .w           (w),
        .fpos        (fpos)
    );

    logic          hit_p0;
    logic [IW-1:0] idx_p0;
    int            lx_p0;
    int            ly_p0;
    int            weff_p0;
    logic          band_p0;
    logic          face_p0;

    always_comb begin
        hit_p0 = 1'b0;
        idx_p0 = '0;
        lx_p0  = 0;
        ly_p0  = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((int'(hcount) >= ORIGIN_X + c * PITCH_X) &&
                    (int'(hcount) <  ORIGIN_X + c * PITCH_X + CARD_W) &&
                    (int'(vcount) >= ORIGIN_Y + r * PITCH_Y) &&
                    (int'(vcount) <  ORIGIN_Y + r * PITCH_Y + CARD_H)) begin
                    hit_p0 = 1'b1;
                    idx_p0 = IW'(r * COLS + c);
                    lx_p0  = int'(hcount) - ORIGIN_X - c * PITCH_X;
                    ly_p0  = int'(vcount) - ORIGIN_Y - r * PITCH_Y;
                end
            end
        end
    end

    // Only the card being flipped is narrowed; w rests at CARD_W when idle.
    assign weff_p0 = (idx_p0 == fpos) ? int'(w) : CARD_W;
    assign band_p0 = in_band(lx_p0, weff_p0, CARD_W);
    assign face_p0 = face_up[idx_p0];

    logic           hit_p1;
    logic           band_p1;
    logic           face_p1;
    logic [LXW-1:0] lx_p1;

    // ---- S1: hit-test, band and face sampled; local row presented to the ROM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_p1   <= 1'b0;
            band_p1  <= 1'b0;
            face_p1  <= 1'b0;
            lx_p1    <= '0;
            rom_addr <= '0;
        end else begin
            hit_p1   <= hit_p0;
            band_p1  <= band_p0;
            face_p1  <= face_p0;
            lx_p1    <= LXW'(lx_p0);
            rom_addr <= AW'(ly_p0);
        end
    end

    // ---- S2: colour select using the ROM row returned for S1's address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cardon <= 1'b0;
            rgb    <= BG_RGB;
        end else if (hit_p1 && band_p1) begin
            cardon <= 1'b1;
            rgb    <= face_p1 ? rom_data[3 * int'(lx_p1) +: 3] : BACK_RGB;
        end else begin
            cardon <= 1'b0;
            rgb    <= BG_RGB;
        end
    end

endmodule

// File: tb/tb_card_grid_flip_renderer.sv
// Directed bench for card_grid_flip_renderer: pixel tables plus flip, abort and reset sequences.
module tb_card_grid_flip_renderer;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [9:0]   hcount, vcount;
    logic         frame_start, flip_req, flip_face, reset_board;
    logic [3:0]   flip_pos;
    logic         flip_busy;
    logic [15:0]  face_up;
    logic [6:0]   rom_addr;
    logic [269:0] rom_data;
    logic         cardon;
    logic [2:0]   rgb;

    logic         flip_req3, reset_board3;
    logic [3:0]   flip_pos3;
    logic         flip_busy3;
    logic [11:0]  face_up3;
    logic [6:0]   rom_addr3;
    logic         cardon3;
    logic [2:0]   rgb3;

    card_grid_flip_renderer dut (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .flip_req(flip_req), .flip_pos(flip_pos),
        .flip_face(flip_face), .reset_board(reset_board), .flip_busy(flip_busy),
        .face_up(face_up), .rom_addr(rom_addr), .rom_data(rom_data),
        .cardon(cardon), .rgb(rgb)
    );

    card_grid_flip_renderer #(.ROWS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .flip_req(flip_req3), .flip_pos(flip_pos3),
        .flip_face(flip_face), .reset_board(reset_board3), .flip_busy(flip_busy3),
        .face_up(face_up3), .rom_addr(rom_addr3), .rom_data(rom_data),
        .cardon(cardon3), .rgb(rgb3)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         h;
        int         v;
        logic       on;
        logic [2:0] col;
        int         addr;
    } vec_t;

    vec_t         vt[14];
    vec_t         rt[6];
    logic [269:0] rom_pat;
    int           exp_w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v);
        hcount = 10'(h);
        vcount = 10'(v);
        tick();
        tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_vec(input string nm, input vec_t t);
        pix(t.h, t.v);
        chk(nm, {28'd0, cardon, rgb}, {28'd0, t.on, (t.on ? t.col : 3'b000)});
        if (t.on) chk({nm, "_addr"}, 32'(rom_addr), 32'(t.addr));
    endtask

    initial begin
        vt[0]  = '{130,  70, 1'b1, 3'b100, 0};
        vt[1]  = '{219,  70, 1'b1, 3'b100, 0};
        vt[2]  = '{220,  70, 1'b0, 3'b000, 0};
        vt[3]  = '{229,  70, 1'b0, 3'b000, 0};
        vt[4]  = '{230, 170, 1'b1, 3'b100, 0};
        vt[5]  = '{129,  70, 1'b0, 3'b000, 0};
        vt[6]  = '{130, 159, 1'b1, 3'b100, 89};
        vt[7]  = '{130, 160, 1'b0, 3'b000, 0};
        vt[8]  = '{430, 370, 1'b1, 3'b100, 0};
        vt[9]  = '{519, 459, 1'b1, 3'b100, 89};
        vt[10] = '{520, 370, 1'b0, 3'b000, 0};
        vt[11] = '{430, 460, 1'b0, 3'b000, 0};
        vt[12] = '{0,     0, 1'b0, 3'b000, 0};
        vt[13] = '{130,  75, 1'b1, 3'b100, 5};

        rt[0] = '{230, 170, 1'b1, 3'b011, 0};
        rt[1] = '{231, 170, 1'b1, 3'b110, 0};
        rt[2] = '{319, 170, 1'b1, 3'b101, 0};
        rt[3] = '{250, 175, 1'b1, 3'b010, 5};
        rt[4] = '{320, 170, 1'b0, 3'b000, 0};
        rt[5] = '{130,  70, 1'b1, 3'b100, 0};

        rom_pat = '0;
        for (int i = 0; i < 90; i++) rom_pat[3*i +: 3] = 3'b010;
        rom_pat[2:0]     = 3'b011;
        rom_pat[5:3]     = 3'b110;
        rom_pat[269:267] = 3'b101;

        rst_n = 1'b1; hcount = '0; vcount = '0; frame_start = 1'b0;
        flip_req = 1'b0; flip_pos = '0; flip_face = 1'b0; reset_board = 1'b0;
        flip_req3 = 1'b0; flip_pos3 = '0; reset_board3 = 1'b0; rom_data = '0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_cardon", 32'(cardon), 32'd0);
        chk("rst_busy", 32'(flip_busy), 32'd0);
        chk("rst_face", 32'(face_up), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_w", 32'(dut.u_ctrl.w), 32'd90);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) run_vec($sformatf("tbl%0d", i), vt[i]);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                pix(175 + 100 * c, 115 + 100 * r);
                chk($sformatf("sweep_r%0dc%0d", r, c), {28'd0, cardon, rgb}, 32'hC);
            end

        pix(220, 70);
        hcount = 10'd130; vcount = 10'd70;
        tick();
        chk("lat_1clk", 32'(cardon), 32'd0);
        tick();
        chk("lat_2clk", {28'd0, cardon, rgb}, 32'hC);

        // Flip card 5 up; frame_start in the accept cycle must not step w.
        flip_pos = 4'd5; flip_face = 1'b1; flip_req = 1'b1; frame_start = 1'b1;
        tick();
        flip_req = 1'b0; frame_start = 1'b0;
        chk("accept_busy", 32'(flip_busy), 32'd1);
        chk("accept_w", 32'(dut.u_ctrl.w), 32'd90);

        for (int f = 1; f <= 18; f++) begin
            if (f == 5) begin
                flip_pos = 4'd2; flip_req = 1'b1;
            end
            frame();
            flip_req = 1'b0;
            if (f <= 8)       exp_w = 90 - 10 * f;
            else if (f == 9)  exp_w = 0;
            else if (f < 18)  exp_w = 10 * (f - 9);
            else              exp_w = 90;
            chk($sformatf("flip_w_f%0d", f), 32'(dut.u_ctrl.w), 32'(exp_w));
            chk($sformatf("flip_busy_f%0d", f), 32'(flip_busy), (f < 18) ? 32'd1 : 32'd0);
            chk($sformatf("flip_face_f%0d", f), 32'(face_up), (f >= 9) ? 32'h20 : 32'h0);
            if (f == 3) begin
                pix(230, 170);
                chk("f3_edge_off", 32'(cardon), 32'd0);
                pix(275, 170);
                chk("f3_mid_back", {28'd0, cardon, rgb}, 32'hC);
                pix(230, 70);
                chk("f3_other_full", {28'd0, cardon, rgb}, 32'hC);
            end
            if (f == 9) begin
                pix(275, 170);
                chk("f9_invisible", 32'(cardon), 32'd0);
            end
            if (f == 12) begin
                pix(275, 170);
                chk("f12_face_rom0", {28'd0, cardon, rgb}, 32'h8);
                pix(250, 170);
                chk("f12_outside_band", 32'(cardon), 32'd0);
            end
        end

        rom_data = rom_pat;
        for (int i = 0; i < 6; i++) run_vec($sformatf("rom%0d", i), rt[i]);

        // Out-of-range index on the 3-row grid is dropped; a valid one is accepted.
        flip_pos3 = 4'd12; flip_req3 = 1'b1;
        tick();
        chk("oor12_busy", 32'(flip_busy3), 32'd0);
        flip_pos3 = 4'd15;
        tick();
        flip_req3 = 1'b0;
        tick();
        chk("oor15_busy", 32'(flip_busy3), 32'd0);
        chk("oor_face", 32'(face_up3), 32'd0);
        flip_pos3 = 4'd11; flip_req3 = 1'b1;
        tick();
        flip_req3 = 1'b0;
        chk("valid11_busy", 32'(flip_busy3), 32'd1);
        reset_board3 = 1'b1;
        tick();
        reset_board3 = 1'b0;
        chk("dut3_rb_busy", 32'(flip_busy3), 32'd0);

        // reset_board with a simultaneous request mid-SHRINK.
        flip_pos = 4'd3; flip_face = 1'b1; flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        frame(); frame();
        chk("rb_pre_w", 32'(dut.u_ctrl.w), 32'd70);
        reset_board = 1'b1; flip_req = 1'b1; flip_pos = 4'd6;
        tick();
        reset_board = 1'b0; flip_req = 1'b0;
        chk("rb_busy", 32'(flip_busy), 32'd0);
        chk("rb_w", 32'(dut.u_ctrl.w), 32'd90);
        chk("rb_face", 32'(face_up), 32'd0);
        tick();
        chk("rb_req_dropped", 32'(flip_busy), 32'd0);
        frame();
        chk("rb_w_hold", 32'(dut.u_ctrl.w), 32'd90);

        // rst_n pulsed low mid-GROW.
        flip_pos = 4'd0; flip_face = 1'b1; flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        for (int f = 0; f < 10; f++) frame();
        chk("grow_w", 32'(dut.u_ctrl.w), 32'd10);
        chk("grow_busy", 32'(flip_busy), 32'd1);
        pix(175, 100);
        chk("grow_pix", {28'd0, cardon, rgb}, 32'hA);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rgb", 32'(rgb), 32'd0);
        chk("arst_cardon", 32'(cardon), 32'd0);
        chk("arst_busy", 32'(flip_busy), 32'd0);
        chk("arst_face", 32'(face_up), 32'd0);
        chk("arst_addr", 32'(rom_addr), 32'd0);
        chk("arst_w", 32'(dut.u_ctrl.w), 32'd90);
        #1 rst_n = 1'b1;
        pix(130, 70);
        chk("post_rst_edge", {28'd0, cardon, rgb}, 32'hC);
        pix(175, 100);
        chk("post_rst_mid", {28'd0, cardon, rgb}, 32'hC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
